hazard_unit: RTL and testbench
==============================

Name: hazard_unit

Overview:
- Backward-direction companion to the pipelined control path.
- The controller pushes control bits forward DEC->EXE->MEM->WB. This block returns stall, flush and forwarding-select signals to the fetch/decode registers and the EXE operand muxes.
- It keeps its own register-tag pipeline, mirroring the controller's stage registers, so it needs only decode-stage register numbers plus the MEM-stage branch outcome.

Parameters:
- REGW, 5, register-number width.
- FWDW, 2, forwarding-select width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- rs_DEC  in  REGW  source register A of instruction in DEC
- rt_DEC  in  REGW  source register B / I-type destination in DEC
- rd_DEC  in  REGW  R-type destination in DEC
- regwrite_DEC  in  1  DEC instruction writes the register file
- memtoreg_DEC  in  1  DEC instruction is a load
- regdst_DEC  in  1  1 = destination is rd, 0 = rt
- pcsrc_MEM  in  1  taken branch resolved in MEM
- stall_FET  out  1  hold PC
- stall_DEC  out  1  hold IF/ID register
- flush_DEC  out  1  clear IF/ID register
- flush_EXE  out  1  clear ID/EX register, including controller EXE bits
- flush_MEM  out  1  clear EX/MEM register, including controller MEM bits
- forwardA_EXE  out  FWDW  operand A select: 00 = regfile, 01 = WB result, 10 = MEM ALU result
- forwardB_EXE  out  FWDW  operand B select, same encoding

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Reset state: all tag-pipeline valid/regwrite/memtoreg bits cleared; register fields zeroed.
  - With pcsrc_MEM=0, every output is 0 (stall 0, flush 0, forward 00) from the cycle after reset is sampled.
  - Reset has priority over stall and flush.
- Tag pipeline, three stages (EXE, MEM, WB), each holding: valid, regwrite, memtoreg, rs, rt, writereg.
  - writereg_EXE = regdst ? rd : rt, computed when DEC is captured into EXE.
  - Each clock edge: DEC->EXE, EXE->MEM, MEM->WB.
  - flush_EXE invalidates the EXE slot being loaded. flush_MEM invalidates the MEM slot being loaded.
  - An invalid slot, or writereg = 0, never matches anything.
- Load-use detect (combinational): lu = valid_EXE & memtoreg_EXE & regwrite_EXE & writereg_EXE≠0 & (writereg_EXE==rs_DEC | writereg_EXE==rt_DEC).
- Output equations:
  - stall_FET = stall_DEC = lu & ~pcsrc_MEM.
  - flush_EXE = lu | pcsrc_MEM.
  - flush_DEC = flush_MEM = pcsrc_MEM.
  - A taken branch overrides a load-use stall: no stall in that cycle, because the younger instructions are discarded.
- Load-use latency: exactly one bubble. The next cycle the load is in MEM, lu drops, and the dependent instruction enters EXE and gets its value from WB-stage forwarding one cycle later. Result: one stall cycle per load-use pair; back-to-back dependent loads give one stall each.
- Forwarding (combinational from the tag pipeline):
  - forwardA_EXE = 10 if valid_MEM & regwrite_MEM & writereg_MEM≠0 & writereg_MEM==rs_EXE.
  - Else 01 if the same condition holds for the WB stage.
  - Else 00.
  - forwardB_EXE is identical, using rt_EXE.
  - MEM has priority over WB, so the youngest producer wins.
  - A load in MEM is never a forwarding source (memtoreg_MEM=1 suppresses the 10 match). The stall guarantees it is never needed.
- Flush timing: pcsrc_MEM is high for one cycle. On the following edge, the EXE and MEM slots are invalid and no forwarding from squashed instructions can occur. WB is unaffected, since the branch itself is older.
- Reset mid-operation: all slots are invalidated on the edge reset is sampled. No stall or flush state persists.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- Defined: adds two outputs, stall_count[31:0] and flush_count[31:0].
  - stall_count increments on each cycle with stall_DEC=1.
  - flush_count increments on each cycle with pcsrc_MEM=1.
  - Both wrap modulo 2^32 and clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: lw $2 in EXE, add $3,$2,$4 in DEC -> stall_FET=stall_DEC=flush_EXE=1 for exactly one cycle. Two cycles later, with add in EXE and lw in WB, forwardA_EXE=01, forwardB_EXE=00.
- ALU-ALU: add $2,$1,$1 followed by sub $5,$2,$2 -> in sub's EXE cycle forwardA_EXE=forwardB_EXE=10; no stall.
- Priority and $0: add $2 then or $2 then and $6,$2,$0 -> forwardA_EXE=10 (youngest producer); writes to $0 give forward 00 and no stall.
- Branch taken: pcsrc_MEM=1 for one cycle -> flush_DEC=flush_EXE=flush_MEM=1 that cycle. Next cycle, with a dependent instruction in EXE, forwarding from squashed producers stays 00.
- Flush vs load-use: lu condition and pcsrc_MEM=1 in the same cycle -> stall_FET=stall_DEC=0, flush_EXE=1, flush_DEC=1.
- Reset mid-stream: assert reset during a load-use stall -> next cycle all outputs 0. With HAZARD_PERF_EN defined, stall_count=0 and flush_count=0.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall, flush and forwarding-select generator for the five-stage
// pipeline. It tracks register tags through its own EXE/MEM/WB pipeline, so
// it only needs decode-stage register numbers and the MEM-stage branch outcome.
// Optional feature: define HAZARD_PERF_EN to add the stall_count/flush_count
// performance counters.
module hazard_unit #(
    parameter int REGW = 5,
    parameter int FWDW = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [REGW-1:0] rs_DEC,
    input  logic [REGW-1:0] rt_DEC,
    input  logic [REGW-1:0] rd_DEC,
    input  logic            regwrite_DEC,
    input  logic            memtoreg_DEC,
    input  logic            regdst_DEC,
    input  logic            pcsrc_MEM,
    output logic            stall_FET,
    output logic            stall_DEC,
    output logic            flush_DEC,
    output logic            flush_EXE,
    output logic            flush_MEM,
    output logic [FWDW-1:0] forwardA_EXE,
    output logic [FWDW-1:0] forwardB_EXE
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]     stall_count,
    output logic [31:0]     flush_count
`endif
);

    // One slot of the tag pipeline.
    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memtoreg;
        logic [REGW-1:0] rs;
        logic [REGW-1:0] rt;
        logic [REGW-1:0] writereg;
    } tag_t;

    localparam logic [FWDW-1:0] FWD_NONE = FWDW'(0);
    localparam logic [FWDW-1:0] FWD_WB   = FWDW'(1);
    localparam logic [FWDW-1:0] FWD_MEM  = FWDW'(2);

    tag_t exe_q, exe_d;
    tag_t mem_q, mem_d;
    tag_t wb_q,  wb_d;

    logic load_use;

    // Load in EXE whose destination is read by the instruction sitting in DEC.
    always_comb begin
        load_use = exe_q.valid && exe_q.memtoreg && exe_q.regwrite &&
                   (exe_q.writereg != '0) &&
                   ((exe_q.writereg == rs_DEC) || (exe_q.writereg == rt_DEC));
    end

    // Stall/flush outputs; a taken branch discards the stalled instructions,
    // so it cancels the load-use stall for that cycle.
    always_comb begin
        stall_FET = load_use && !pcsrc_MEM;
        stall_DEC = load_use && !pcsrc_MEM;
        flush_EXE = load_use || pcsrc_MEM;
        flush_DEC = pcsrc_MEM;
        flush_MEM = pcsrc_MEM;
    end

    // Next-state of the tag pipeline; flushed slots are loaded as all-zero.
    always_comb begin
        exe_d = '0;
        if (!flush_EXE) begin
            exe_d.valid    = 1'b1;
            exe_d.regwrite = regwrite_DEC;
            exe_d.memtoreg = memtoreg_DEC;
            exe_d.rs       = rs_DEC;
            exe_d.rt       = rt_DEC;
            exe_d.writereg = regdst_DEC ? rd_DEC : rt_DEC;
        end
        mem_d = flush_MEM ? '0 : exe_q;
        wb_d  = mem_q;
    end

    // Tag pipeline registers; reset clears every slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            exe_q <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            exe_q <= exe_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // Per-operand forwarding select: gi=0 is operand A (rs), gi=1 is operand B (rt).
    // MEM beats WB so the youngest producer wins; a load in MEM has no data yet.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic [REGW-1:0] src;
        logic [FWDW-1:0] sel;

        assign src = (gi == 0) ? exe_q.rs : exe_q.rt;

        // Priority compare against the MEM then WB producers.
        always_comb begin
            sel = FWD_NONE;
            if (mem_q.valid && mem_q.regwrite && !mem_q.memtoreg &&
                (mem_q.writereg != '0) && (mem_q.writereg == src)) begin
                sel = FWD_MEM;
            end else if (wb_q.valid && wb_q.regwrite &&
                         (wb_q.writereg != '0) && (wb_q.writereg == src)) begin
                sel = FWD_WB;
            end
        end
    end

    assign forwardA_EXE = g_fwd[0].sel;
    assign forwardB_EXE = g_fwd[1].sel;

    // The WB slot keeps the full tag for symmetry with the controller, but
    // its source fields and load flag are not consulted.
    logic unused_wb_fields;
    assign unused_wb_fields = ^{wb_q.rs, wb_q.rt, wb_q.memtoreg};

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [31:0] flush_count_q, flush_count_d;

    // Counter increments: one per stalled cycle and one per taken branch.
    always_comb begin
        stall_count_d = stall_count_q + (stall_DEC ? 32'd1 : 32'd0);
        flush_count_d = flush_count_q + (pcsrc_MEM ? 32'd1 : 32'd0);
    end

    // Counter registers, cleared on reset and wrapping naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Table-driven bench for hazard_unit: each row is one cycle of decode-stage
// stimulus with the hand-computed hazard outputs for that cycle.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_DEC, rt_DEC, rd_DEC;
    logic       regwrite_DEC, memtoreg_DEC, regdst_DEC, pcsrc_MEM;
    logic       stall_FET, stall_DEC, flush_DEC, flush_EXE, flush_MEM;
    logic [1:0] forwardA_EXE, forwardB_EXE;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count, flush_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REGW(5), .FWDW(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .rs_DEC      (rs_DEC),
        .rt_DEC      (rt_DEC),
        .rd_DEC      (rd_DEC),
        .regwrite_DEC(regwrite_DEC),
        .memtoreg_DEC(memtoreg_DEC),
        .regdst_DEC  (regdst_DEC),
        .pcsrc_MEM   (pcsrc_MEM),
        .stall_FET   (stall_FET),
        .stall_DEC   (stall_DEC),
        .flush_DEC   (flush_DEC),
        .flush_EXE   (flush_EXE),
        .flush_MEM   (flush_MEM),
        .forwardA_EXE(forwardA_EXE),
        .forwardB_EXE(forwardB_EXE)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count (stall_count),
        .flush_count (flush_count)
`endif
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt, rd;
        logic       rw, mtr, rdst, pc;
        logic       stall, fdec, fexe, fmem;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                logic rw, logic mtr, logic rdst, logic pc,
                                logic s, logic fd, logic fe, logic fm,
                                logic [1:0] fa, logic [1:0] fb);
        vec_t v;
        v.name = n; v.rs = rs; v.rt = rt; v.rd = rd;
        v.rw = rw; v.mtr = mtr; v.rdst = rdst; v.pc = pc;
        v.stall = s; v.fdec = fd; v.fexe = fe; v.fmem = fm;
        v.fa = fa; v.fb = fb;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rs_DEC = v.rs; rt_DEC = v.rt; rd_DEC = v.rd;
        regwrite_DEC = v.rw; memtoreg_DEC = v.mtr; regdst_DEC = v.rdst;
        pcsrc_MEM = v.pc;
    endtask

    // Compare all outputs at the negedge, then advance past the next posedge.
    task automatic apply(input int idx, input vec_t v);
        logic [8:0] got, exp;
        drive(v);
        @(negedge clk);
        got = {stall_FET, stall_DEC, flush_DEC, flush_EXE, flush_MEM, forwardA_EXE, forwardB_EXE};
        exp = {v.stall, v.stall, v.fdec, v.fexe, v.fmem, v.fa, v.fb};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %0d %s got %b required %b (sF sD fD fE fM fa fb)", idx, v.name, got, exp);
        end else begin
            $display("ok   %0d %s outputs %b", idx, v.name, got);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t nop(string n, logic [1:0] fa, logic [1:0] fb);
        return mk(n, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb);
    endfunction

    // R-type (rd <- rs op rt) with no hazard output expected.
    function automatic vec_t rty(string n, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        return mk(n, rs, rt, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    endfunction

    initial begin
        int exp_stalls;
        int exp_flushes;
        vec_t v;

        // Load-use: one bubble, then WB forwarding.
        vecs.push_back(nop("reset_state", 2'b00, 2'b00));
        vecs.push_back(mk("lu_lw2", 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("lu_stall", 2, 4, 3, 1, 0, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk("lu_one_bubble", 2, 4, 3, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(nop("lu_wb_fwd", 2'b01, 2'b00));
        // ALU-ALU forwarding from MEM.
        vecs.push_back(rty("alu_add2", 1, 1, 2));
        vecs.push_back(rty("alu_sub5", 2, 2, 5));
        vecs.push_back(nop("alu_mem_fwd", 2'b10, 2'b10));
        // Youngest producer wins.
        vecs.push_back(rty("pri_add2", 1, 1, 2));
        vecs.push_back(rty("pri_or2", 3, 3, 2));
        vecs.push_back(rty("pri_and6", 2, 0, 6));
        vecs.push_back(nop("pri_youngest", 2'b10, 2'b00));
        // Writes to $0 never forward or stall.
        vecs.push_back(rty("z_add0", 1, 1, 0));
        vecs.push_back(rty("z_use0", 0, 0, 7));
        vecs.push_back(nop("z_mem_r0", 2'b00, 2'b00));
        vecs.push_back(mk("z_lw0", 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(rty("z_lw0_nostall", 0, 0, 8));
        vecs.push_back(nop("z_idle", 2'b00, 2'b00));
        // Taken branch squashes EXE and MEM producers.
        vecs.push_back(rty("br_add10", 1, 1, 10));
        vecs.push_back(rty("br_add11", 1, 1, 11));
        vecs.push_back(mk("br_taken", 10, 11, 12, 1, 0, 1, 1, 0, 1, 1, 1, 2'b00, 2'b00));
        vecs.push_back(rty("br_after", 10, 11, 12));
        vecs.push_back(nop("br_no_fwd", 2'b00, 2'b00));
        // Branch beats load-use stall.
        vecs.push_back(mk("flu_lw13", 1, 13, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("flu_branch_wins", 13, 13, 14, 1, 0, 1, 1, 0, 1, 1, 1, 2'b00, 2'b00));
        vecs.push_back(nop("flu_after", 2'b00, 2'b00));
        // Back-to-back dependent loads: one stall each.
        vecs.push_back(mk("bb_lw2", 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("bb_lw3_stall", 2, 3, 0, 1, 1, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00));
        vecs.push_back(mk("bb_lw3_go", 2, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        vecs.push_back(mk("bb_add_stall", 3, 3, 4, 1, 0, 1, 0, 1, 0, 1, 0, 2'b01, 2'b00));
        vecs.push_back(rty("bb_add_go", 3, 3, 4));
        vecs.push_back(nop("bb_wb_fwd", 2'b01, 2'b01));
        vecs.push_back(nop("idle", 2'b00, 2'b00));

        // Reset preamble.
        reset = 1'b1;
        drive(nop("rst", 2'b00, 2'b00));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        exp_stalls = 0;
        exp_flushes = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].stall) exp_stalls++;
            if (vecs[i].pc) exp_flushes++;
            apply(i, vecs[i]);
        end

`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_count !== 32'(exp_stalls) || flush_count !== 32'(exp_flushes)) begin
            errors++;
            $display("FAIL perf_counts got stall %0d flush %0d required stall %0d flush %0d",
                     stall_count, flush_count, exp_stalls, exp_flushes);
        end else begin
            $display("ok   perf_counts stall %0d flush %0d", stall_count, flush_count);
        end
`endif

        // Reset asserted in the middle of a load-use stall.
        apply(100, mk("rst_lw2", 1, 2, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00));
        v = mk("rst_stall", 2, 4, 3, 1, 0, 1, 0, 1, 0, 1, 0, 2'b00, 2'b00);
        apply(101, v);
        reset = 1'b1;
        drive(v);
        @(posedge clk);
        #1;
        reset = 1'b0;
        apply(102, mk("rst_cleared", 2, 4, 3, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00));
`ifdef HAZARD_PERF_EN
        checks++;
        if (stall_count !== 32'd0 || flush_count !== 32'd0) begin
            errors++;
            $display("FAIL perf_reset got stall %0d flush %0d required 0 0", stall_count, flush_count);
        end else begin
            $display("ok   perf_reset counters cleared");
        end
`endif
        apply(103, nop("rst_idle", 2'b00, 2'b00));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
